// File: rtl/dm_access_ctrl_if.sv
// Bus bundle for the data-memory access controller: the core request/response
// channel, the debug request/response channel and the single-port memory port.
// The controller sits on the slave side; requesters and the memory model sit
// on the master side.
interface dm_access_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 9
);

  // Core channel: load/store/push/pop
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [1:0]    cpu_op;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rsp_valid;
  logic          cpu_rsp_err;
  logic [DW-1:0] cpu_rdata;

  // Debug channel: raw 16-bit addressed read/write
  logic          dbg_req_valid;
  logic          dbg_req_ready;
  logic          dbg_we;
  logic [15:0]   dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_rsp_valid;
  logic [DW-1:0] dbg_rdata;

  // Single-port synchronous memory, one cycle read latency
  logic          mem_en;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Requesters and memory side
  modport master (
    output cpu_req_valid, cpu_op, cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata,
    output dbg_req_valid, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Controller side
  modport slave (
    input  cpu_req_valid, cpu_op, cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata,
    input  dbg_req_valid, dbg_we, dbg_addr, dbg_wdata,
    output dbg_req_ready, dbg_rsp_valid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer and arbiter.
// Two requesters (core, debug) share one single-port 64K x 16 memory through a
// three-state sequence IDLE -> ISSUE -> DONE, giving one operation every three
// cycles. Round-robin arbitration between the requesters; the controller owns
// the stack pointer and guards it against overflow and underflow.
module dm_access_ctrl #(
  parameter int          DW          = 16,
  parameter int          AW          = 9,
  parameter logic [15:0] STACK_BASE  = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic               clk,
  input  logic               rst_b,
  dm_access_ctrl_if.slave    bus,
  output logic [15:0]        sp,
  output logic               stack_ovf,
  output logic               stack_unf,
  input  logic               err_clr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  // Lowest legal sp value: the stack holds no free slot below this.
  localparam logic [15:0] SP_FULL = STACK_LIMIT - 16'd1;

  // True when a push at this sp would leave the stack region.
  function automatic logic stack_full(input logic [15:0] sp_v);
    return (sp_v == SP_FULL);
  endfunction

  // True when a pop at this sp would read above the stack base.
  function automatic logic stack_empty(input logic [15:0] sp_v);
    return (sp_v == STACK_BASE);
  endfunction

  // Sequencer state and arbitration pointer
  logic [1:0]    state_r;
  logic          pref_dbg_r;      // 1: debug wins a tie next time

  // Stack pointer and sticky guard flags
  logic [15:0]   sp_r;
  logic          ovf_r;
  logic          unf_r;

  // Registered memory port
  logic          mem_en_r;
  logic          mem_we_r;
  logic [15:0]   mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  // Context of the operation in flight
  logic          txn_dbg_r;
  logic          txn_read_r;
  logic          txn_rej_r;
  logic          sp_dec_r;
  logic          sp_inc_r;

  // Registered response strobes
  logic          cpu_rsp_valid_r;
  logic          cpu_rsp_err_r;
  logic          dbg_rsp_valid_r;

  // Arbitration and handshake decode
  logic          grant_cpu_s;
  logic          grant_dbg_s;
  logic          hs_s;
  logic [15:0]   cpu_addr_ext_s;

  // Memory cycle decode for the winning request
  logic          iss_we_s;
  logic [15:0]   iss_addr_s;
  logic [DW-1:0] iss_wdata_s;
  logic          iss_read_s;
  logic          iss_rej_s;
  logic          set_ovf_s;
  logic          set_unf_s;
  logic          sp_dec_s;
  logic          sp_inc_s;

  assign cpu_addr_ext_s = {{(16-AW){1'b0}}, bus.cpu_addr};

  // Round-robin grant; only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_dbg_s = 1'b0;
    if ((state_r == ST_IDLE) && rst_b) begin
      if (bus.cpu_req_valid && bus.dbg_req_valid) begin
        if (pref_dbg_r) begin
          grant_dbg_s = 1'b1;
        end else begin
          grant_cpu_s = 1'b1;
        end
      end else if (bus.cpu_req_valid) begin
        grant_cpu_s = 1'b1;
      end else if (bus.dbg_req_valid) begin
        grant_dbg_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
      end
    end else begin
      grant_cpu_s = 1'b0;
      grant_dbg_s = 1'b0;
    end
  end

  assign hs_s              = grant_cpu_s | grant_dbg_s;
  assign bus.cpu_req_ready = grant_cpu_s;
  assign bus.dbg_req_ready = grant_dbg_s;

  // Translate the winning request into a memory cycle, applying the stack guard.
  always_comb begin
    iss_we_s    = 1'b0;
    iss_addr_s  = 16'h0000;
    iss_wdata_s = {DW{1'b0}};
    iss_read_s  = 1'b0;
    iss_rej_s   = 1'b0;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    sp_dec_s    = 1'b0;
    sp_inc_s    = 1'b0;
    if (grant_dbg_s) begin
      iss_we_s    = bus.dbg_we;
      iss_addr_s  = bus.dbg_addr;
      iss_wdata_s = bus.dbg_we ? bus.dbg_wdata : {DW{1'b0}};
      iss_read_s  = ~bus.dbg_we;
    end else if (grant_cpu_s) begin
      case (bus.cpu_op)
        OP_LOAD: begin
          iss_addr_s = cpu_addr_ext_s;
          iss_read_s = 1'b1;
        end
        OP_STORE: begin
          iss_addr_s  = cpu_addr_ext_s;
          iss_we_s    = 1'b1;
          iss_wdata_s = bus.cpu_wdata;
        end
        OP_PUSH: begin
          if (stack_full(sp_r)) begin
            iss_rej_s = 1'b1;
            set_ovf_s = 1'b1;
          end else begin
            iss_addr_s  = sp_r;
            iss_we_s    = 1'b1;
            iss_wdata_s = bus.cpu_wdata;
            sp_dec_s    = 1'b1;
          end
        end
        OP_POP: begin
          if (stack_empty(sp_r)) begin
            iss_rej_s = 1'b1;
            set_unf_s = 1'b1;
          end else begin
            iss_addr_s = sp_r + 16'd1;
            iss_read_s = 1'b1;
            sp_inc_s   = 1'b1;
          end
        end
        default: begin
          iss_rej_s = 1'b0;
        end
      endcase
    end else begin
      iss_rej_s = 1'b0;
    end
  end

  // Sequencer: one handshake, one memory cycle, one response cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_r <= hs_s ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_r <= ST_DONE;
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Round-robin pointer: after a grant, the other requester wins the next tie.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pref_dbg_r <= 1'b0;
    end else if (hs_s) begin
      pref_dbg_r <= grant_cpu_s;
    end else begin
      pref_dbg_r <= pref_dbg_r;
    end
  end

  // Memory port: loaded at the handshake so it is live during ISSUE only;
  // a rejected stack op leaves the port idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= {DW{1'b0}};
    end else if (hs_s && !iss_rej_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= iss_we_s;
      mem_addr_r  <= iss_addr_s;
      mem_wdata_r <= iss_wdata_s;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= {DW{1'b0}};
    end
  end

  // Operation context, held from the handshake until the next one.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      txn_dbg_r  <= 1'b0;
      txn_read_r <= 1'b0;
      txn_rej_r  <= 1'b0;
      sp_dec_r   <= 1'b0;
      sp_inc_r   <= 1'b0;
    end else if (hs_s) begin
      txn_dbg_r  <= grant_dbg_s;
      txn_read_r <= iss_read_s;
      txn_rej_r  <= iss_rej_s;
      sp_dec_r   <= sp_dec_s;
      sp_inc_r   <= sp_inc_s;
    end else begin
      txn_dbg_r  <= txn_dbg_r;
      txn_read_r <= txn_read_r;
      txn_rej_r  <= txn_rej_r;
      sp_dec_r   <= sp_dec_r;
      sp_inc_r   <= sp_inc_r;
    end
  end

  // Response strobes: raised for the DONE cycle of the owning requester.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cpu_rsp_valid_r <= 1'b0;
      cpu_rsp_err_r   <= 1'b0;
      dbg_rsp_valid_r <= 1'b0;
    end else if (state_r == ST_ISSUE) begin
      cpu_rsp_valid_r <= ~txn_dbg_r;
      cpu_rsp_err_r   <= ~txn_dbg_r & txn_rej_r;
      dbg_rsp_valid_r <= txn_dbg_r;
    end else begin
      cpu_rsp_valid_r <= 1'b0;
      cpu_rsp_err_r   <= 1'b0;
      dbg_rsp_valid_r <= 1'b0;
    end
  end

  // Stack pointer moves at the end of ISSUE, so a reset during ISSUE drops it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_r <= STACK_BASE;
    end else if ((state_r == ST_ISSUE) && sp_dec_r) begin
      sp_r <= sp_r - 16'd1;
    end else if ((state_r == ST_ISSUE) && sp_inc_r) begin
      sp_r <= sp_r + 16'd1;
    end else begin
      sp_r <= sp_r;
    end
  end

  // Sticky guard flags; a new violation outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (set_ovf_s) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (set_unf_s) begin
        unf_r <= 1'b1;
      end else if (err_clr) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign bus.mem_en        = mem_en_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.cpu_rsp_valid = cpu_rsp_valid_r;
  assign bus.cpu_rsp_err   = cpu_rsp_err_r;
  assign bus.dbg_rsp_valid = dbg_rsp_valid_r;

  // Read data arrives from the memory's own output register in DONE; it is
  // steered by registered qualifiers and forced to zero for writes and rejects.
  assign bus.cpu_rdata = (cpu_rsp_valid_r && txn_read_r) ? bus.mem_rdata : {DW{1'b0}};
  assign bus.dbg_rdata = (dbg_rsp_valid_r && txn_read_r) ? bus.mem_rdata : {DW{1'b0}};

  assign sp        = sp_r;
  assign stack_ovf = ovf_r;
  assign stack_unf = unf_r;

endmodule
